// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing and pixel-doubled read of a
// 320x240 3-bit framebuffer through a synchronous read port.
module vga_scanout #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33
) (
  input  logic        clock,
  input  logic        reset,
  output logic [16:0] mem_addr,
  input  logic [2:0]  mem_data,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        pix_en;
  logic [9:0]  h;
  logic [9:0]  v;
  logic        h_last;
  logic        v_last;
  logic        vis;
  logic        hs_n;
  logic        vs_n;
  logic [16:0] fb_y;
  logic [16:0] fb_x;
  logic [16:0] addr;

  logic        vis_d;
  logic        hs_d;
  logic        vs_d;
  logic [2:0]  rd_hold;
  logic [2:0]  px;
  logic [2:0]  rgb;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign vis    = (h < H_VIS) && (v < V_VIS);
  assign hs_n   = !((h >= HS_BEG) && (h < HS_END));
  assign vs_n   = !((v >= VS_BEG) && (v < VS_END));

  // y*320 + x built from shifts; x,y are the halved counters
  assign fb_y = {8'b0, v[9:1]};
  assign fb_x = {8'b0, h[9:1]};
  assign addr = (fb_y << 8) + (fb_y << 6) + fb_x;

  // With one clock of latency the data is only guaranteed for one
  // clock, so it is caught on the off cycle; two clocks lands it
  // exactly on the next pixel edge.
  assign px = (READ_LATENCY == 1) ? rd_hold : mem_data;

  assign VGA_SYNC_N = 1'b0;
  assign VGA_R      = {8{rgb[2]}};
  assign VGA_G      = {8{rgb[1]}};
  assign VGA_B      = {8{rgb[0]}};

  // pixel enable divider and the pixel clock derived from it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en  <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      pix_en  <= ~pix_en;
      VGA_CLK <= pix_en;
    end
  end

  // raster counters, one step per pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // address issue plus control delayed to meet the returning data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      vis_d       <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        mem_addr <= vis ? addr : 17'd0;
        vis_d    <= vis;
        hs_d     <= hs_n;
        vs_d     <= vs_n;
      end
    end
  end

  // capture read data on the off cycle for the short-latency port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_hold <= '0;
    end else if (!pix_en && vis_d) begin
      rd_hold <= mem_data;
    end
  end

  // pin stage: colour, blank and syncs move together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb         <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
    end else if (pix_en) begin
      rgb         <= vis_d ? px : 3'b000;
      VGA_BLANK_N <= vis_d;
      VGA_HS      <= hs_d;
      VGA_VS      <= vs_d;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: random framebuffer contents, both read latencies
// side by side, checked every clock against a raster-arithmetic model.
module tb_vga_scanout;

  localparam int HT  = 800;
  localparam int HVI = 640;
  localparam int HSB = 656;
  localparam int HSE = 752;
  localparam int VVI = 8;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int VT  = VVI + VFP + VSY + VBP;
  localparam int FR  = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [16:0] ma_a, ma_b;
  logic [2:0]  md_a, md_b;
  logic        fs_a, fs_b;
  logic        vck_a, vck_b;
  logic        hs_a, hs_b;
  logic        vs_a, vs_b;
  logic        bn_a, bn_b;
  logic        sn_a, sn_b;
  logic [7:0]  r_a, g_a, b_a;
  logic [7:0]  r_b, g_b, b_b;

  logic [2:0] mem [0:76799];

  int c;
  int n_chk = 0;
  int n_err = 0;
  bit run_chk = 1'b0;

  int hs_f1 = -1, hs_r1 = -1, hs_f2 = -1;
  int vs_f1 = -1, vs_r1 = -1, vs_f2 = -1;
  int fs_1 = -1, fs_n = 0;
  logic hs_p = 1'b1, vs_p = 1'b1;

  always #10 clk = ~clk;

  vga_scanout #(
    .READ_LATENCY(1),
    .V_VISIBLE(VVI), .V_FRONT(VFP),
    .V_SYNC(VSY), .V_BACK(VBP)
  ) u_a (
    .clock(clk), .reset(rst),
    .mem_addr(ma_a), .mem_data(md_a),
    .frame_start(fs_a), .VGA_CLK(vck_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  vga_scanout #(
    .READ_LATENCY(2),
    .V_VISIBLE(VVI), .V_FRONT(VFP),
    .V_SYNC(VSY), .V_BACK(VBP)
  ) u_b (
    .clock(clk), .reset(rst),
    .mem_addr(ma_b), .mem_data(md_b),
    .frame_start(fs_b), .VGA_CLK(vck_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  // one-clock read port and two-clock read port
  assign md_a = mem[ma_a];
  always @(posedge clk) md_b <= mem[ma_b];

  always @(posedge clk or posedge rst)
    if (rst) c <= 0;
    else     c <= c + 1;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (clk %0d)",
               tag, got, exp, c);
    end
  endtask

  function automatic int px_h(int p);
    return p % HT;
  endfunction

  function automatic int px_v(int p);
    return (p / HT) % VT;
  endfunction

  function automatic bit px_vis(int p);
    return px_h(p) < HVI && px_v(p) < VVI;
  endfunction

  function automatic int px_addr(int p);
    return (px_v(p) / 2) * 320 + px_h(p) / 2;
  endfunction

  function automatic logic [23:0] px_rgb(int p);
    logic [2:0] d;
    if (!px_vis(p)) return 24'h0;
    d = mem[px_addr(p)];
    return {{8{d[2]}}, {8{d[1]}}, {8{d[0]}}};
  endfunction

  // c counts clock edges since reset release; pixel k is consumed by
  // the counters at edge 2k+2 and reaches the pins one pixel later
  always @(negedge clk) begin
    int m, p, h, v;
    logic [31:0] e_ck, e_ma, e_fs, e_hs, e_vs, e_bn;
    logic [31:0] e_rgb;
    if (!rst && run_chk) begin
      m    = c / 2;
      e_ck = 32'(c >= 2 && c % 2 == 0);
      e_fs = 32'(c >= 2 && c % 2 == 0 && m % FR == 0);
      e_ma = 0;
      if (m >= 1 && px_vis(m - 1))
        e_ma = 32'(px_addr(m - 1));
      e_hs = 1; e_vs = 1; e_bn = 0; e_rgb = 0;
      if (m >= 2) begin
        p     = m - 2;
        h     = px_h(p);
        v     = px_v(p);
        e_hs  = 32'(!(h >= HSB && h < HSE));
        e_vs  = 32'(!(v >= VVI + VFP && v < VVI + VFP + VSY));
        e_bn  = 32'(px_vis(p));
        e_rgb = 32'(px_rgb(p));
      end
      check_eq("clk_a", 32'(vck_a), e_ck);
      check_eq("clk_b", 32'(vck_b), e_ck);
      check_eq("addr_a", 32'(ma_a), e_ma);
      check_eq("addr_b", 32'(ma_b), e_ma);
      check_eq("fs_a", 32'(fs_a), e_fs);
      check_eq("fs_b", 32'(fs_b), e_fs);
      check_eq("hs_a", 32'(hs_a), e_hs);
      check_eq("hs_b", 32'(hs_b), e_hs);
      check_eq("vs_a", 32'(vs_a), e_vs);
      check_eq("vs_b", 32'(vs_b), e_vs);
      check_eq("blank_a", 32'(bn_a), e_bn);
      check_eq("blank_b", 32'(bn_b), e_bn);
      check_eq("rgb_a", {8'h0, r_a, g_a, b_a}, e_rgb);
      check_eq("rgb_b", {8'h0, r_b, g_b, b_b}, e_rgb);
      check_eq("sync_n_a", 32'(sn_a), 32'd0);
      check_eq("sync_n_b", 32'(sn_b), 32'd0);
    end
  end

  // edge timestamps for period and pulse-width checks
  always @(negedge clk) begin
    if (rst) begin
      hs_f1 = -1; hs_r1 = -1; hs_f2 = -1;
      vs_f1 = -1; vs_r1 = -1; vs_f2 = -1;
      fs_1 = -1; fs_n = 0;
      hs_p = 1'b1; vs_p = 1'b1;
    end else begin
      if (hs_p && !hs_a) begin
        if (hs_f1 < 0) hs_f1 = c;
        else if (hs_f2 < 0) hs_f2 = c;
      end
      if (!hs_p && hs_a && hs_r1 < 0) hs_r1 = c;
      if (vs_p && !vs_a) begin
        if (vs_f1 < 0) vs_f1 = c;
        else if (vs_f2 < 0) vs_f2 = c;
      end
      if (!vs_p && vs_a && vs_r1 < 0) vs_r1 = c;
      if (fs_a) begin
        if (fs_1 < 0) fs_1 = c;
        fs_n++;
      end
      hs_p = hs_a;
      vs_p = vs_a;
    end
  end

  task automatic check_reset_pins();
    check_eq("rst_addr", {15'h0, ma_a}, 32'd0);
    check_eq("rst_fs", 32'({fs_a, fs_b}), 32'd0);
    check_eq("rst_clk", 32'({vck_a, vck_b}), 32'd0);
    check_eq("rst_hs", 32'({hs_a, hs_b}), 32'd3);
    check_eq("rst_vs", 32'({vs_a, vs_b}), 32'd3);
    check_eq("rst_blank", 32'({bn_a, bn_b}), 32'd0);
    check_eq("rst_rgb", {8'h0, r_a, g_b, b_a}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 76800; i++)
      mem[i] = 3'($urandom);
    mem[0] = 3'b111;
    mem[5] = 3'b101;

    #35;
    check_reset_pins();
    run_chk = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // run into line 3, around pixel 300, then reset asynchronously
    repeat (2 * (3 * HT + 300)) @(posedge clk);
    check_eq("mid_blank", 32'(bn_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_pins();
    repeat (3) @(negedge clk);
    check_reset_pins();
    rst = 1'b0;

    repeat (2 * FR * 2 + 2000) @(posedge clk);
    @(negedge clk);

    check_eq("hs_first_fall", 32'(hs_f1), 32'(2 * (HSB + 2)));
    check_eq("hs_low", 32'(hs_r1 - hs_f1), 32'(2 * (HSE - HSB)));
    check_eq("hs_period", 32'(hs_f2 - hs_f1), 32'(2 * HT));
    check_eq("vs_first_fall", 32'(vs_f1),
             32'(2 * ((VVI + VFP) * HT + 2)));
    check_eq("vs_low", 32'(vs_r1 - vs_f1), 32'(2 * VSY * HT));
    check_eq("vs_period", 32'(vs_f2 - vs_f1), 32'(2 * FR));
    check_eq("fs_first", 32'(fs_1), 32'(2 * FR));
    check_eq("fs_count", 32'(fs_n), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
